// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the serial binary-to-BCD converter:
//     - state_t      : FSM state encodings (ST_IDLE, ST_SHIFT, ST_DONE)
//     - BCD_DIGIT_W  : bits per BCD digit
//     - cnt_width()  : width of the shift counter for a given binary width
//     - min_digits() : decimal digits needed to show 2**width-1 without loss
//   No ports; imported by bcd_add3_cell and bin2bcd_serial.
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // One spare bit over $clog2 so the counter can also represent WIDTH
    // itself, which keeps the "last shift" compare simple for any WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Number of decimal digits in the largest unsigned value of 'width' bits.
    // Valid for widths up to 63.
    function automatic int min_digits(input int width);
        longint unsigned max_val;
        int              digits;
        max_val = (64'd1 << width) - 64'd1;
        digits  = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_val >= 64'd10) begin
                max_val = max_val / 64'd10;
                digits++;
            end
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// ---------------------------------------------------------------------------
// bcd_add3_cell
//   Combinational digit correction for the shift-and-add-3 algorithm: a BCD
//   digit of 5 or more gets 3 added so that the following left shift carries
//   correctly into the next decimal digit. The sum is kept to 4 bits; any
//   carry is deliberately discarded because the shift supplies it.
// Ports
//   digit     in   4   scratch digit before correction
//   adjusted  out  4   digit after conditional +3
// ---------------------------------------------------------------------------
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        adjusted = digit;
        if (digit >= BCD_DIGIT_W'(5)) begin
            adjusted = digit + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// ---------------------------------------------------------------------------
// bin2bcd_serial
//   Sequential binary-to-BCD converter using shift-and-add-3, one input bit
//   per clock. A start request in IDLE loads the binary value; WIDTH shift
//   cycles later the DONE state copies the scratch digits into the result
//   registers and pulses oDone. Results hold between conversions so a
//   downstream display stays stable.
// Parameters
//   WIDTH      binary input width
//   DIGITS     number of BCD output digits
// Ports
//   iClk       in   1          system clock
//   iRst       in   1          synchronous, active-high reset
//   iNum       in   WIDTH      unsigned value, sampled only on accepted start
//   iStart     in   1          conversion request, honoured only in IDLE
//   oBusy      out  1          high while a conversion is in SHIFT or DONE
//   oDone      out  1          one-cycle pulse when oBcd/oOverflow update
//   oBcd       out  4*DIGITS   digit k in bits [4k+3:4k], digit 0 = units
//   oOverflow  out  1          value exceeded 10**DIGITS-1 (oBcd = value mod
//                              10**DIGITS)
// ---------------------------------------------------------------------------
module bin2bcd_serial
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic [WIDTH-1:0]              iNum,
    input  logic                          iStart,
    output logic                          oBusy,
    output logic                          oDone,
    output logic [BCD_DIGIT_W*DIGITS-1:0] oBcd,
    output logic                          oOverflow
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;

    // When DIGITS is large enough for every WIDTH-bit value, nothing can ever
    // fall out of the top digit; folding this in lets synthesis drop the
    // overflow logic entirely for such configurations.
    localparam bit DIGITS_SUFFICIENT = (DIGITS >= min_digits(WIDTH));

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0] digits_sr;
    logic [BCD_W-1:0] digits_adj;
    logic             ovf_sr;
    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  shifted;
    logic             dropped_bit;

    // Per-digit correction, applied to the scratch digits before each shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3_cell u_add3 (
            .digit    (digits_sr [BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .adjusted (digits_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // The binary MSB moves into the units digit LSB; the corrected top
    // digit's MSB is the bit lost off the end and marks overflow.
    assign shifted     = {digits_adj, bin_sr} << 1;
    assign dropped_bit = digits_adj[BCD_W-1];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            // NOTE: every register here, state included, uses non-blocking assignment so all of them update together from pre-edge values.
            state     <= ST_IDLE;
            bin_sr    <= '0;
            digits_sr <= '0;
            ovf_sr    <= 1'b0;
            cnt       <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oBcd      <= '0;
            oOverflow <= 1'b0;
        end else begin
            oDone <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        bin_sr    <= iNum;
                        digits_sr <= '0;
                        ovf_sr    <= 1'b0;
                        cnt       <= '0;
                        oBusy     <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    digits_sr <= shifted[SR_W-1:WIDTH];
                    bin_sr    <= shifted[WIDTH-1:0];
                    ovf_sr    <= ovf_sr | (dropped_bit & ~DIGITS_SUFFICIENT);
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Digits are already final here; no correction after the
                    // last shift.
                    oBcd      <= digits_sr;
                    oOverflow <= ovf_sr;
                    oDone     <= 1'b1;
                    oBusy     <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_serial
//   Directed bench for bin2bcd_serial. Two instances share clock and
//   stimulus: a 3-digit converter (full range of 8-bit input) and a 2-digit
//   converter that exercises overflow. Inputs change and outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  num;
    logic        start;

    logic        busy, done, ovf;
    logic [11:0] bcd;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iNum      (num),
        .iStart    (start),
        .oBusy     (busy),
        .oDone     (done),
        .oBcd      (bcd),
        .oOverflow (ovf)
    );

    bin2bcd_serial #(.WIDTH(8), .DIGITS(2)) dut2 (
        .iClk      (clk),
        .iRst      (rst),
        .iNum      (num),
        .iStart    (start),
        .oBusy     (busy2),
        .oDone     (done2),
        .oBcd      (bcd2),
        .oOverflow (ovf2)
    );

    // Reference decimal digits of v, built with divide/modulo.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Pulses start for one cycle with 'value', then waits (bounded) for
    // oDone. lat = falling edges from acceptance to oDone; 20 means timeout.
    task automatic run_conversion(input logic [7:0] value, output int lat);
        @(negedge clk);
        num   = value;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        num   = 8'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        vectors++;
        if (bcd !== 12'h000 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_result: got bcd=%h ovf=%b expected 000/0", bcd, ovf);
        end
        vectors++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || bcd2 !== 8'h00 || ovf2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut2: got busy=%b done=%b bcd=%h ovf=%b expected all 0",
                     busy2, done2, bcd2, ovf2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat;
        run_conversion(8'd0, lat);
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d expected 9", lat);
        end
        vectors++;
        if (bcd !== 12'h000 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_result: got bcd=%h ovf=%b expected 000/0", bcd, ovf);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_busy_at_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  nums [8] = '{8'd255, 8'd100, 8'd9, 8'd10, 8'd37, 8'd128, 8'd199, 8'd99};
        logic [11:0] exps [8] = '{12'h255, 12'h100, 12'h009, 12'h010,
                                  12'h037, 12'h128, 12'h199, 12'h099};
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_conversion(nums[i], lat);
            vectors++;
            if (lat !== 9) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d expected 9", nums[i], lat);
            end
            vectors++;
            if (bcd !== exps[i] || ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_bcd[%0d]: got bcd=%h ovf=%b expected %h/0",
                         nums[i], bcd, ovf, exps[i]);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        run_conversion(8'd142, lat);
        vectors++;
        if (lat !== 9 || done2 !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_done: got lat=%0d done2=%b expected 9/1", lat, done2);
        end
        // Result must stay put and oDone must stay low while idle.
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bcd !== 12'h142 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL hold_stable: got %0d bad idle cycles (bcd=%h done=%b) expected 0",
                     bad, bcd, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        int          lat;
        @(negedge clk);
        num   = 8'd0;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            start = 1'b0;
            exp   = to_bcd(i);
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_busy_start[%0d]: got %b expected 1", i, busy);
            end
            lat = 0;
            while (done !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            vectors++;
            if (lat !== 9 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_timing[%0d]: got lat=%0d busy=%b expected 9/0", i, lat, busy);
            end
            vectors++;
            if (bcd !== exp || ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_bcd[%0d]: got %h/%b expected %h/0", i, bcd, ovf, exp);
            end
            vectors++;
            if (bcd2 !== exp[7:0] || ovf2 !== (i > 99)) begin
                miscompares++;
                $display("FAIL b2b_bcd2[%0d]: got %h/%b expected %h/%b",
                         i, bcd2, ovf2, exp[7:0], (i > 99));
            end
            // Next start lands on the only idle cycle: maximum rate.
            if (i < 255) begin
                num   = 8'(i + 1);
                start = 1'b1;
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_tail: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        num   = 8'd37;
        start = 1'b1;
        @(negedge clk);
        num   = 8'd200;  // start stays high, value changes mid-conversion
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL ignore_latency: got %0d expected 9", lat);
        end
        vectors++;
        if (bcd !== 12'h037 || bcd2 !== 8'h37) begin
            miscompares++;
            $display("FAIL ignore_value: got %h/%h expected 037/37", bcd, bcd2);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_restart: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int pulses;
        @(negedge clk);
        num   = 8'd255;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_ctrl: got busy=%b done=%b expected 0/0", busy, done);
        end
        vectors++;
        if (bcd !== 12'h000 || ovf !== 1'b0 || bcd2 !== 8'h00 || ovf2 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_result: got %h/%b %h/%b expected 000/0 00/0",
                     bcd, ovf, bcd2, ovf2);
        end
        rst    = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || done2 === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end
        run_conversion(8'd255, lat);
        vectors++;
        if (lat !== 9 || bcd !== 12'h255) begin
            miscompares++;
            $display("FAIL abort_recover: got lat=%0d bcd=%h expected 9/255", lat, bcd);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        num   = 8'd200;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wins_busy: got %b expected 0", busy);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bcd !== 12'h000) begin
            miscompares++;
            $display("FAIL rst_wins_idle: got busy=%b bcd=%h expected 0/000", busy, bcd);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_conversion(8'd255, lat);
        vectors++;
        if (lat !== 9 || done2 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_timing: got lat=%0d done2=%b expected 9/1", lat, done2);
        end
        vectors++;
        if (bcd2 !== 8'h55 || ovf2 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_255: got %h/%b expected 55/1", bcd2, ovf2);
        end
        run_conversion(8'd99, lat);
        vectors++;
        if (bcd2 !== 8'h99 || ovf2 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_99: got %h/%b expected 99/0", bcd2, ovf2);
        end
        run_conversion(8'd100, lat);
        vectors++;
        if (bcd2 !== 8'h00 || ovf2 !== 1'b1 || bcd !== 12'h100) begin
            miscompares++;
            $display("FAIL ovf_100: got %h/%b (3-digit %h) expected 00/1 (100)", bcd2, ovf2, bcd);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        num   = 8'd0;
        test_reset();
        test_zero();
        test_directed();
        test_hold();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_reset_priority();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
